// File: rtl/m_div_pkg.sv
`default_nettype none
// ============================================================================
// Module      : m_div_pkg
// Description : Shared definitions for the iterative divider: FSM state
//               encoding and two's-complement helpers (absolute value and
//               negate) used for sign handling around the unsigned core.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package m_div_pkg;

    // Divider FSM states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_t;

    // The helpers work on a fixed 64-bit word. Callers zero-extend their
    // WIDTH-bit operand and truncate the result. This is exact for two's
    // complement because the low WIDTH bits of a negate depend only on the
    // low WIDTH bits of the input. The divider therefore supports WIDTH <= 64.
    localparam int C_FN_W = 64;
    typedef logic [C_FN_W-1:0] fn_word_t;

    function automatic fn_word_t f_negate(input fn_word_t value);
        return ~value + fn_word_t'(1);
    endfunction

    // The sign cannot be recovered from a zero-extended value, so the caller
    // passes it explicitly.
    function automatic fn_word_t f_abs(input fn_word_t value, input logic is_neg);
        return is_neg ? f_negate(value) : value;
    endfunction

endpackage : m_div_pkg
`default_nettype wire

// File: rtl/m_div_step.sv
`default_nettype none
// ============================================================================
// Module      : m_div_step
// Description : One radix-2 restoring division iteration. It shifts
//               {rem, quo} left by one bit and trial-subtracts the divisor.
//               The subtraction is kept if it does not go negative, and the
//               resulting quotient bit is shifted in at quo[0].
// Ports       : i_rem      [WIDTH:0]   partial remainder
//               i_quo      [WIDTH-1:0] partial quotient / remaining dividend bits
//               i_divisor  [WIDTH-1:0] divisor magnitude
//               o_rem_next [WIDTH:0]   partial remainder after this step
//               o_quo_next [WIDTH-1:0] partial quotient after this step
// Revision    : 1.0 - initial release
// ============================================================================
module m_div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   i_rem,
    input  logic [WIDTH-1:0] i_quo,
    input  logic [WIDTH-1:0] i_divisor,
    output logic [WIDTH:0]   o_rem_next,
    output logic [WIDTH-1:0] o_quo_next
);

    // The shift and trial use one extra guard bit. Because the partial
    // remainder stays below the divisor, the top bit of w_trial is the sign
    // of (rem_shifted - divisor).
    logic [WIDTH+1:0] w_shifted;
    logic [WIDTH+1:0] w_trial;

    always_comb begin
        w_shifted  = {i_rem, i_quo[WIDTH-1]};
        w_trial    = w_shifted - {2'b00, i_divisor};
        o_rem_next = w_shifted[WIDTH:0];
        o_quo_next = {i_quo[WIDTH-2:0], 1'b0};
        if (!w_trial[WIDTH+1]) begin
            o_rem_next = w_trial[WIDTH:0];
            o_quo_next = {i_quo[WIDTH-2:0], 1'b1};
        end
    end

endmodule : m_div_step
`default_nettype wire

// File: rtl/m_iter_divider.sv
`default_nettype none
// ============================================================================
// Module      : m_iter_divider
// Description : Multi-cycle signed/unsigned integer divider. It computes one
//               quotient bit per cycle (radix-2 restoring) and follows RISC-V
//               M results for a zero divisor and for signed overflow.
//               Results are held until the consumer accepts them.
// Ports       : i_clk        clock, rising edge
//               i_reset_n    synchronous active-low reset
//               i_start      request a division (ignored while busy)
//               i_signed     1 = div/rem, 0 = divu/remu
//               i_dividend   [WIDTH-1:0] dividend
//               i_divisor    [WIDTH-1:0] divisor
//               i_ready      consumer accepts the result
//               o_busy       unit is not idle
//               o_valid      result is present
//               o_quotient   [WIDTH-1:0] quotient
//               o_remainder  [WIDTH-1:0] remainder (sign follows dividend)
//               o_div_zero   result came from a zero divisor
// Revision    : 1.0 - initial release
// ============================================================================
module m_iter_divider
    import m_div_pkg::*;
#(
    parameter int WIDTH = 32  // 4 <= WIDTH <= 64
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic             i_start,
    input  logic             i_signed,
    input  logic [WIDTH-1:0] i_dividend,
    input  logic [WIDTH-1:0] i_divisor,
    input  logic             i_ready,
    output logic             o_busy,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_quotient,
    output logic [WIDTH-1:0] o_remainder,
    output logic             o_div_zero
);

    localparam int               CNT_W      = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] C_ALL_ONES = '1;
    localparam logic [WIDTH-1:0] C_MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

    div_state_t       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH:0]   r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_dvsr;
    logic             r_q_neg;
    logic             r_r_neg;
    logic             r_busy;
    logic             r_valid;
    logic             r_div_zero;
    logic [WIDTH-1:0] r_quotient;
    logic [WIDTH-1:0] r_remainder;

    logic             w_dvd_neg;
    logic             w_dvs_neg;
    logic [WIDTH-1:0] w_dvd_abs;
    logic [WIDTH-1:0] w_dvs_abs;
    logic             w_zero_div;
    logic             w_overflow;
    logic [WIDTH:0]   w_rem_next;
    logic [WIDTH-1:0] w_quo_next;
    logic [WIDTH-1:0] w_quo_final;
    logic [WIDTH-1:0] w_rem_final;

    // Operand signs only matter in signed mode, so unsigned mode never negates.
    assign w_dvd_neg  = i_signed & i_dividend[WIDTH-1];
    assign w_dvs_neg  = i_signed & i_divisor[WIDTH-1];
    // The most-negative dividend's magnitude still fits in WIDTH unsigned bits.
    assign w_dvd_abs  = WIDTH'(f_abs(fn_word_t'(i_dividend), w_dvd_neg));
    assign w_dvs_abs  = WIDTH'(f_abs(fn_word_t'(i_divisor), w_dvs_neg));
    assign w_zero_div = (i_divisor == '0);
    assign w_overflow = i_signed && (i_dividend == C_MIN_NEG) && (i_divisor == C_ALL_ONES);

    m_div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .i_rem      (r_rem),
        .i_quo      (r_quo),
        .i_divisor  (r_dvsr),
        .o_rem_next (w_rem_next),
        .o_quo_next (w_quo_next)
    );

    // Sign correction is applied to the last iteration's output so the
    // result registers load on the same edge that enters DONE.
    assign w_quo_final = r_q_neg ? WIDTH'(f_negate(fn_word_t'(w_quo_next))) : w_quo_next;
    assign w_rem_final = r_r_neg ? WIDTH'(f_negate(fn_word_t'(w_rem_next[WIDTH-1:0])))
                                 : w_rem_next[WIDTH-1:0];

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_rem       <= '0;
            r_quo       <= '0;
            r_dvsr      <= '0;
            r_q_neg     <= 1'b0;
            r_r_neg     <= 1'b0;
            r_busy      <= 1'b0;
            r_valid     <= 1'b0;
            r_div_zero  <= 1'b0;
            r_quotient  <= '0;
            r_remainder <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_start) begin
                        r_busy <= 1'b1;
                        if (w_zero_div) begin
                            r_state     <= DONE;
                            r_valid     <= 1'b1;
                            r_div_zero  <= 1'b1;
                            r_quotient  <= C_ALL_ONES;
                            r_remainder <= i_dividend;
                        end else if (w_overflow) begin
                            r_state     <= DONE;
                            r_valid     <= 1'b1;
                            r_div_zero  <= 1'b0;
                            r_quotient  <= i_dividend;
                            r_remainder <= '0;
                        end else begin
                            r_state    <= CALC;
                            r_div_zero <= 1'b0;
                            r_rem      <= '0;
                            r_quo      <= w_dvd_abs;
                            r_dvsr     <= w_dvs_abs;
                            r_q_neg    <= w_dvd_neg ^ w_dvs_neg;
                            r_r_neg    <= w_dvd_neg;
                            r_cnt      <= CNT_W'(WIDTH);
                        end
                    end
                end
                CALC: begin
                    r_rem <= w_rem_next;
                    r_quo <= w_quo_next;
                    r_cnt <= r_cnt - CNT_W'(1);
                    if (r_cnt == CNT_W'(1)) begin
                        r_state     <= DONE;
                        r_valid     <= 1'b1;
                        r_quotient  <= w_quo_final;
                        r_remainder <= w_rem_final;
                    end
                end
                DONE: begin
                    // Result registers keep their values after the handshake.
                    if (i_ready) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                        r_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign o_busy      = r_busy;
    assign o_valid     = r_valid;
    assign o_quotient  = r_quotient;
    assign o_remainder = r_remainder;
    assign o_div_zero  = r_div_zero;

endmodule : m_iter_divider
`default_nettype wire

// File: tb/tb_m_iter_divider.sv
`default_nettype none
// ============================================================================
// Module      : tb_m_iter_divider
// Description : Directed self-checking bench for m_iter_divider. It drives a
//               WIDTH=32 and a WIDTH=8 instance from one clock and compares
//               against hand-computed quotients, remainders and latencies.
// Ports       : none
// Revision    : 1.0 - initial release
// ============================================================================
module tb_m_iter_divider;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n;
    logic        signed_op;
    logic        ready;
    logic        start32;
    logic        start8;
    logic [31:0] dvd32;
    logic [31:0] dvs32;
    logic [7:0]  dvd8;
    logic [7:0]  dvs8;

    logic        busy32, valid32, dz32;
    logic [31:0] q32, r32;
    logic        busy8, valid8, dz8;
    logic [7:0]  q8, r8;

    int n_vec = 0;
    int n_err = 0;

    m_iter_divider #(.WIDTH(32)) u_dut32 (
        .i_clk       (clk),
        .i_reset_n   (reset_n),
        .i_start     (start32),
        .i_signed    (signed_op),
        .i_dividend  (dvd32),
        .i_divisor   (dvs32),
        .i_ready     (ready),
        .o_busy      (busy32),
        .o_valid     (valid32),
        .o_quotient  (q32),
        .o_remainder (r32),
        .o_div_zero  (dz32)
    );

    m_iter_divider #(.WIDTH(8)) u_dut8 (
        .i_clk       (clk),
        .i_reset_n   (reset_n),
        .i_start     (start8),
        .i_signed    (signed_op),
        .i_dividend  (dvd8),
        .i_divisor   (dvs8),
        .i_ready     (ready),
        .o_busy      (busy8),
        .o_valid     (valid8),
        .o_quotient  (q8),
        .o_remainder (r8),
        .o_div_zero  (dz8)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one division and check busy at cycle 1, the latency to o_valid,
    // the result fields, and the return to idle after the handshake.
    task automatic run_div(input string tag, input bit w8, input bit sgn,
                           input logic [31:0] a, input logic [31:0] b,
                           input int exp_lat, input logic [31:0] exp_q,
                           input logic [31:0] exp_r, input bit exp_z);
        int lat;
        signed_op = sgn;
        if (w8) begin
            dvd8 = a[7:0]; dvs8 = b[7:0]; start8 = 1'b1;
        end else begin
            dvd32 = a; dvs32 = b; start32 = 1'b1;
        end
        tick();
        start8  = 1'b0;
        start32 = 1'b0;
        lat = 1;
        check({tag, " busy@1"}, 64'(w8 ? busy8 : busy32), 64'd1);
        while (!(w8 ? valid8 : valid32) && lat < 200) begin
            tick();
            lat++;
        end
        check({tag, " latency"}, 64'(lat), 64'(exp_lat));
        check({tag, " quotient"}, w8 ? 64'(q8) : 64'(q32), 64'(exp_q));
        check({tag, " remainder"}, w8 ? 64'(r8) : 64'(r32), 64'(exp_r));
        check({tag, " div_zero"}, 64'(w8 ? dz8 : dz32), 64'(exp_z));
        ready = 1'b1;
        tick();
        ready = 1'b0;
        check({tag, " idle busy"}, 64'(w8 ? busy8 : busy32), 64'd0);
        check({tag, " idle valid"}, 64'(w8 ? valid8 : valid32), 64'd0);
    endtask

    initial begin
        reset_n   = 1'b0;
        signed_op = 1'b0;
        ready     = 1'b0;
        start32   = 1'b0;
        start8    = 1'b0;
        dvd32     = '0;
        dvs32     = '0;
        dvd8      = '0;
        dvs8      = '0;
        repeat (3) tick();
        reset_n = 1'b1;

        check("reset busy", 64'(busy32), 64'd0);
        check("reset valid", 64'(valid32), 64'd0);
        check("reset quotient", 64'(q32), 64'd0);
        check("reset remainder", 64'(r32), 64'd0);
        check("reset div_zero", 64'(dz32), 64'd0);
        check("reset8 valid", 64'(valid8), 64'd0);

        // WIDTH = 32 vectors
        run_div("u100/7",   1'b0, 1'b0, 32'd100, 32'd7, 33, 32'd14, 32'd2, 1'b0);
        run_div("s-7/2",    1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
        run_div("s7/-2",    1'b0, 1'b1, 32'd7, 32'hFFFF_FFFE, 33, 32'hFFFF_FFFD, 32'd1, 1'b0);
        run_div("s-100/-7", 1'b0, 1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 33, 32'd14, 32'hFFFF_FFFE, 1'b0);
        run_div("u5/0",     1'b0, 1'b0, 32'd5, 32'd0, 1, 32'hFFFF_FFFF, 32'd5, 1'b1);
        run_div("s5/0",     1'b0, 1'b1, 32'd5, 32'd0, 1, 32'hFFFF_FFFF, 32'd5, 1'b1);
        run_div("s-ovf",    1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h8000_0000, 32'd0, 1'b0);
        run_div("u-ovfops", 1'b0, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'd0, 32'h8000_0000, 1'b0);
        run_div("uMAX/1",   1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1, 33, 32'hFFFF_FFFF, 32'd0, 1'b0);

        // Backpressure with i_start pulses while busy: 1000 / 10 = 100 r 0
        signed_op = 1'b0;
        dvd32 = 32'd1000; dvs32 = 32'd10; start32 = 1'b1;
        tick();
        start32 = 1'b0;
        repeat (4) tick();
        dvd32 = 32'd77; dvs32 = 32'd0; start32 = 1'b1;  // pulse during CALC
        tick();
        start32 = 1'b0;
        begin
            int guard = 0;
            while (!valid32 && guard < 100) begin
                tick();
                guard++;
            end
            check("bp reached valid", 64'(valid32), 64'd1);
        end
        for (int i = 0; i < 5; i++) begin
            start32 = (i == 2);  // pulse during DONE
            dvd32   = 32'd50;
            dvs32   = 32'd5;
            check("bp hold valid", 64'(valid32), 64'd1);
            check("bp hold quotient", 64'(q32), 64'd100);
            check("bp hold remainder", 64'(r32), 64'd0);
            tick();
        end
        start32 = 1'b0;
        ready = 1'b1;
        tick();
        ready = 1'b0;
        begin
            int extra = 0;
            for (int i = 0; i < 40; i++) begin
                if (valid32 || busy32) extra++;
                tick();
            end
            check("bp no second result", 64'(extra), 64'd0);
        end
        check("bp kept quotient", 64'(q32), 64'd100);

        // Reset in the middle of a division
        dvd32 = 32'd1000; dvs32 = 32'd7; start32 = 1'b1;
        tick();
        start32 = 1'b0;
        repeat (9) tick();  // now in cycle 10
        reset_n = 1'b0;
        tick();
        check("midrst busy", 64'(busy32), 64'd0);
        check("midrst valid", 64'(valid32), 64'd0);
        check("midrst quotient", 64'(q32), 64'd0);
        check("midrst remainder", 64'(r32), 64'd0);
        check("midrst div_zero", 64'(dz32), 64'd0);
        reset_n = 1'b1;
        run_div("u9/3", 1'b0, 1'b0, 32'd9, 32'd3, 33, 32'd3, 32'd0, 1'b0);

        // WIDTH = 8 vectors
        run_div("w8 u200/3",    1'b1, 1'b0, 32'd200, 32'd3, 9, 32'd66, 32'd2, 1'b0);
        run_div("w8 s-128/3",   1'b1, 1'b1, 32'h80, 32'd3, 9, 32'hD6, 32'hFE, 1'b0);
        run_div("w8 s-128/-1",  1'b1, 1'b1, 32'h80, 32'hFF, 1, 32'h80, 32'd0, 1'b0);
        run_div("w8 u9/0",      1'b1, 1'b0, 32'd9, 32'd0, 1, 32'hFF, 32'd9, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_m_iter_divider
`default_nettype wire
